conv_host_if: RTL and testbench

- Initiator/host side of the conv_top interface.
- Accepts a serial element stream (image pixels, then weights, then bias) and assembles the flattened img/weight/bias vectors conv_top consumes.
- Drives conv_en and waits for conv_fin, then captures the flattened result vector and streams it out one element per handshake.
- Sits between the upstream feature/weight fetch logic and conv_top.

---
 rtl/conv_host_if_pkg.sv | 32 +++
 rtl/conv_host_if_if.sv | 38 +++
 rtl/conv_res_serializer.sv | 57 +++++
 rtl/conv_host_if.sv | 146 ++++++++++++++
 tb/tb_conv_host_if.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_host_if_pkg.sv
// Shared geometry, derived element counts and FSM encoding for the conv_top host interface.
package conv_host_if_pkg;

    localparam int WEIGHT_WIDTH  = 2;
    localparam int WEIGHT_HEIGHT = 2;
    localparam int IMG_WIDTH     = 4;
    localparam int IMG_HEIGHT    = 4;
    localparam int BITWIDTH      = 3;
    localparam int RESULT_WIDTH  = 3;
    localparam int RESULT_HEIGHT = 3;
    localparam int EXPAND        = 1;
    localparam int TIMEOUT       = 1023;

    localparam int NI = IMG_WIDTH * IMG_HEIGHT;
    localparam int NW = WEIGHT_WIDTH * WEIGHT_HEIGHT;
    localparam int NL = NI + NW + 1;
    localparam int NR = RESULT_WIDTH * RESULT_HEIGHT;
    localparam int RW = 2 * EXPAND * BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Counter width able to index n distinct values, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_host_if_if.sv
// Bundle of the load stream, conv_top vectors, result stream and control/status of conv_host_if.
interface conv_host_if_if #(
    parameter int bw       = 3,
    parameter int img_bits = 48,
    parameter int wt_bits  = 12,
    parameter int res_bits = 54,
    parameter int rw       = 6
);
    logic                start;
    logic                busy;
    logic                timeout_err;
    logic [bw-1:0]       in_data;
    logic                in_valid;
    logic                in_ready;
    logic [img_bits-1:0] img;
    logic [wt_bits-1:0]  weight;
    logic [bw-1:0]       bias;
    logic                conv_en;
    logic [res_bits-1:0] result;
    logic                conv_fin;
    logic [rw-1:0]       out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    // slave: the conv_host_if block itself; master: its environment
    modport slave (
        input  start, in_data, in_valid, result, conv_fin, out_ready,
        output busy, timeout_err, in_ready, img, weight, bias, conv_en,
               out_data, out_valid, out_last
    );

    modport master (
        output start, in_data, in_valid, result, conv_fin, out_ready,
        input  busy, timeout_err, in_ready, img, weight, bias, conv_en,
               out_data, out_valid, out_last
    );
endinterface

// File: rtl/conv_res_serializer.sv
// Captures the flattened conv_top result and streams it out one element per valid/ready handshake.
module conv_res_serializer
    import conv_host_if_pkg::*;
#(
    parameter int rw    = 6,
    parameter int n_res = 9
) (
    input  logic                clk_en,
    input  logic                rst_n,
    input  logic                capture,
    input  logic                drain,
    input  logic [n_res*rw-1:0] result,
    input  logic                out_ready,
    output logic [rw-1:0]       out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic                done
);

    localparam int icw = cnt_bits(n_res);
    localparam logic [icw-1:0] last_idx = icw'(n_res - 1);

    logic [n_res*rw-1:0] cap_q, cap_d;
    logic [icw-1:0]      idx_q, idx_d;

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            idx_q <= '0;
        end else begin
            cap_q <= cap_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        cap_d = cap_q;
        idx_d = idx_q;
        done  = 1'b0;
        if (capture) begin
            cap_d = result;
            idx_d = '0;
        end else if (drain && out_ready) begin
            if (idx_q == last_idx) begin
                done  = 1'b1;
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    assign out_data  = cap_q[int'(idx_q)*rw +: rw];
    assign out_valid = drain;
    assign out_last  = drain && (idx_q == last_idx);

endmodule

// File: rtl/conv_host_if.sv
// Host side of conv_top: loads img/weight/bias from a serial stream, runs the convolution
// with a bounded wait on conv_fin, then drains the captured result as a stream.
module conv_host_if
    import conv_host_if_pkg::*;
#(
    parameter int weight_width  = WEIGHT_WIDTH,
    parameter int weight_height = WEIGHT_HEIGHT,
    parameter int img_width     = IMG_WIDTH,
    parameter int img_height    = IMG_HEIGHT,
    parameter int bitwidth      = BITWIDTH,
    parameter int result_width  = RESULT_WIDTH,
    parameter int result_height = RESULT_HEIGHT,
    parameter int expand        = EXPAND,
    parameter int timeout       = TIMEOUT
) (
    input logic        clk_en,
    input logic        rst_n,
    conv_host_if_if.slave bus
);

    localparam int n_img  = img_width * img_height;
    localparam int n_wt   = weight_width * weight_height;
    localparam int n_load = n_img + n_wt + 1;
    localparam int n_res  = result_width * result_height;
    localparam int rw     = 2 * expand * bitwidth;
    localparam int lcw    = cnt_bits(n_load);
    localparam int tcw    = $clog2(timeout + 1);

    state_e                      state_q, state_d;
    logic [lcw-1:0]              ld_cnt_q, ld_cnt_d;
    logic [tcw-1:0]              wait_q, wait_d;
    logic [n_img*bitwidth-1:0]   img_q, img_d;
    logic [n_wt*bitwidth-1:0]    weight_q, weight_d;
    logic [bitwidth-1:0]         bias_q, bias_d;
    logic                        timeout_err_q, timeout_err_d;
    logic                        capture;
    logic                        drain_done;
    logic [rw-1:0]               ser_data;
    logic                        ser_valid;
    logic                        ser_last;
    int                          slot;

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ld_cnt_q      <= '0;
            wait_q        <= '0;
            img_q         <= '0;
            weight_q      <= '0;
            bias_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_cnt_q      <= ld_cnt_d;
            wait_q        <= wait_d;
            img_q         <= img_d;
            weight_q      <= weight_d;
            bias_q        <= bias_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ld_cnt_d      = ld_cnt_q;
        wait_d        = wait_q;
        img_d         = img_q;
        weight_d      = weight_q;
        bias_d        = bias_q;
        timeout_err_d = timeout_err_q;
        capture       = 1'b0;
        slot          = int'(ld_cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_LOAD;
                    ld_cnt_d      = '0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    // Load order is image, then kernel, then the single bias element.
                    if (slot < n_img) begin
                        img_d[slot*bitwidth +: bitwidth] = bus.in_data;
                    end else if (slot < n_img + n_wt) begin
                        weight_d[(slot-n_img)*bitwidth +: bitwidth] = bus.in_data;
                    end else begin
                        bias_d = bus.in_data;
                    end
                    if (ld_cnt_q == lcw'(n_load - 1)) begin
                        state_d = ST_RUN;
                        wait_d  = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.conv_fin) begin
                    capture = 1'b1;
                    state_d = ST_DRAIN;
                end else if (wait_q == tcw'(timeout - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    conv_res_serializer #(
        .rw    (rw),
        .n_res (n_res)
    ) u_serializer (
        .clk_en    (clk_en),
        .rst_n     (rst_n),
        .capture   (capture),
        .drain     (state_q == ST_DRAIN),
        .result    (bus.result),
        .out_ready (bus.out_ready),
        .out_data  (ser_data),
        .out_valid (ser_valid),
        .out_last  (ser_last),
        .done      (drain_done)
    );

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.in_ready    = (state_q == ST_LOAD);
    assign bus.conv_en     = (state_q == ST_RUN);
    assign bus.img         = img_q;
    assign bus.weight      = weight_q;
    assign bus.bias        = bias_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.out_data    = ser_data;
    assign bus.out_valid   = ser_valid;
    assign bus.out_last    = ser_last;

endmodule

// File: tb/tb_conv_host_if.sv
// Self-checking bench for conv_host_if: a conv_top stub plus a scoreboard of expected result elements.
module tb_conv_host_if;

    localparam int BW = 3;
    localparam int NI = 16;
    localparam int NW = 4;
    localparam int NL = NI + NW + 1;
    localparam int NR = 9;
    localparam int RW = 6;
    localparam int TMO = 15;

    logic clk;
    logic rst_n;
    logic finEn;
    int   enCycles;
    int   testsRun;
    int   testsFailed;
    int   popCount;
    int   validCycles;
    int   loadVals [NL];
    int   resVals  [NR];
    int   expQ [$];

    conv_host_if_if #(.bw(BW), .img_bits(NI*BW), .wt_bits(NW*BW), .res_bits(NR*RW), .rw(RW)) bus ();

    conv_host_if #(.timeout(TMO)) dut (
        .clk_en (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // conv_top stub: raise conv_fin once conv_en has been high for four sampled cycles
    always @(posedge clk) enCycles <= bus.conv_en ? enCycles + 1 : 0;
    assign bus.conv_fin = finEn && bus.conv_en && (enCycles >= 4);

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted output element is popped and compared
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) validCycles++;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("sb_extra_pop", 64'(expQ.size()), 64'd1);
            end else begin
                checkOutput("out_data", 64'(bus.out_data), 64'(expQ.pop_front()));
                checkOutput("out_last", 64'(bus.out_last), 64'(expQ.size() == 0));
                popCount++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setNominal();
        int img [NI] = '{3,2,4,1, 2,0,6,2, 6,7,1,2, 5,6,4,2};
        int wt  [NW] = '{1,0,0,1};
        int res [NR] = '{3,8,6,9,1,8,12,11,3};
        for (int k = 0; k < NI; k++) loadVals[k] = img[k];
        for (int k = 0; k < NW; k++) loadVals[NI+k] = wt[k];
        loadVals[NL-1] = 5;
        for (int k = 0; k < NR; k++) resVals[k] = res[k];
    endtask

    task automatic setRandom();
        for (int k = 0; k < NL; k++) loadVals[k] = int'($urandom_range(0, 7));
        for (int k = 0; k < NR; k++) resVals[k] = int'($urandom_range(1, 63));
    endtask

    task automatic driveResult(input bit expectOut);
        logic [NR*RW-1:0] r;
        r = '0;
        for (int k = 0; k < NR; k++) begin
            r[k*RW +: RW] = RW'(resVals[k]);
            if (expectOut) expQ.push_back(resVals[k]);
        end
        bus.result = r;
    endtask

    task automatic startTxn();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("in_ready_on", 64'(bus.in_ready), 64'd1);
        checkOutput("busy_on", 64'(bus.busy), 64'd1);
        checkOutput("terr_clear", 64'(bus.timeout_err), 64'd0);
    endtask

    task automatic applyStimulus(input bit gaps, input bit pulseStart);
        for (int k = 0; k < NL; k++) begin
            bus.in_data  = BW'(loadVals[k]);
            bus.in_valid = 1'b1;
            if (k == NL-1) checkOutput("conv_en_before", 64'(bus.conv_en), 64'd0);
            tick();
            if (gaps && k != NL-1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 3'd7;
                if (pulseStart && k == 5) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("conv_en_lat", 64'(bus.conv_en), 64'd1);
        checkOutput("in_ready_off", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic checkVectors(input bit nominal);
        logic [NI*BW-1:0] eImg;
        logic [NW*BW-1:0] eWt;
        for (int k = 0; k < NI; k++) eImg[k*BW +: BW] = BW'(loadVals[k]);
        for (int k = 0; k < NW; k++) eWt[k*BW +: BW] = BW'(loadVals[NI+k]);
        if (nominal) begin
            eImg = 48'b010_100_110_101_010_001_111_110_010_110_000_010_001_100_010_011;
            eWt  = 12'b001_000_000_001;
        end
        checkOutput("img", 64'(bus.img), 64'(eImg));
        checkOutput("weight", 64'(bus.weight), 64'(eWt));
        checkOutput("bias", 64'(bus.bias), 64'(loadVals[NL-1]));
    endtask

    task automatic runAndDrain(input bit stall, input bit pulseStart);
        int n;
        int base;
        logic [RW-1:0] held;
        base = popCount;
        n = 0;
        while (!bus.conv_fin && n < 50) begin tick(); n++; end
        if (n >= 50) checkOutput("fin_wait_expired", 64'(n), 64'd0);
        checkOutput("valid_pre", 64'(bus.out_valid), 64'd0);
        tick();
        checkOutput("valid_lat", 64'(bus.out_valid), 64'd1);
        checkOutput("conv_en_drop", 64'(bus.conv_en), 64'd0);
        if (pulseStart) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        if (stall) begin
            n = 0;
            while (popCount - base < 4 && n < 50) begin tick(); n++; end
            if (n >= 50) checkOutput("stall_wait_expired", 64'(n), 64'd0);
            bus.out_ready = 1'b0;
            held = bus.out_data;
            checkOutput("stall_elem", 64'(held), 64'(resVals[4]));
            for (int i = 0; i < 5; i++) begin
                tick();
                checkOutput("stall_hold", 64'(bus.out_data), 64'(held));
                checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
            end
            bus.out_ready = 1'b1;
        end
        n = 0;
        while (bus.busy && n < 100) begin tick(); n++; end
        if (n >= 100) checkOutput("drain_wait_expired", 64'(n), 64'd0);
        checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
        checkOutput("pop_count", 64'(popCount - base), 64'(NR));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({tag, "_conv_en"}, 64'(bus.conv_en), 64'd0);
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
        checkOutput({tag, "_terr"}, 64'(bus.timeout_err), 64'd0);
        checkOutput({tag, "_img"}, 64'(bus.img), 64'd0);
        checkOutput({tag, "_weight"}, 64'(bus.weight), 64'd0);
        checkOutput({tag, "_bias"}, 64'(bus.bias), 64'd0);
        checkOutput({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int vc;
        testsRun = 0; testsFailed = 0; popCount = 0; validCycles = 0;
        rst_n = 1'b0; finEn = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.out_ready = 1'b1; bus.result = '0;
        #3;
        checkResetOutputs("rst");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // nominal transaction with the reference image and kernel
        setNominal();
        driveResult(1'b1);
        startTxn();
        applyStimulus(1'b0, 1'b0);
        checkVectors(1'b1);
        runAndDrain(1'b0, 1'b0);
        checkVectors(1'b1);

        // load gaps, start pulses in LOAD and DRAIN, output stall
        setRandom();
        driveResult(1'b1);
        startTxn();
        applyStimulus(1'b1, 1'b1);
        checkVectors(1'b0);
        runAndDrain(1'b1, 1'b1);

        // conv_fin never arrives
        finEn = 1'b0;
        setRandom();
        driveResult(1'b0);
        startTxn();
        applyStimulus(1'b0, 1'b0);
        vc = validCycles;
        n = 0;
        while (bus.conv_en && n < 100) begin tick(); n++; end
        checkOutput("conv_en_cycles", 64'(n), 64'(TMO));
        checkOutput("terr_set", 64'(bus.timeout_err), 64'd1);
        checkOutput("tmo_idle", 64'(bus.busy), 64'd0);
        tick(); tick();
        checkOutput("tmo_no_valid", 64'(validCycles - vc), 64'd0);
        checkOutput("terr_sticky", 64'(bus.timeout_err), 64'd1);
        finEn = 1'b1;
        setRandom();
        driveResult(1'b1);
        startTxn();
        applyStimulus(1'b0, 1'b0);
        checkVectors(1'b0);
        runAndDrain(1'b0, 1'b0);

        // asynchronous reset in the middle of a load
        setNominal();
        startTxn();
        for (int k = 0; k < 7; k++) begin
            bus.in_data = BW'(loadVals[k]);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        #2;
        rst_n = 1'b1;
        tick();
        driveResult(1'b1);
        startTxn();
        applyStimulus(1'b0, 1'b0);
        checkVectors(1'b1);
        runAndDrain(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
